unit_hazard: RTL

Pipeline hazard and stall controller for the five-stage MIPS core; the stalling counterpart to the EX-stage forwarding unit. It stalls in exactly the cases forwarding cannot cover: load-use, branch operands resolved in ID, and a multi-cycle data memory. It drives the PC write enable, the IF/ID write enable, the ID/EX bubble insert, a global pipeline freeze, a debug halt/step FSM and a saturating stall-cycle counter.

---
 rtl/unit_hazard_pkg.sv | 11 +
 rtl/unit_hazard_match.sv | 13 +
 rtl/unit_hazard.sv | 99 +++++++++
 3 files changed

// File: rtl/unit_hazard_pkg.sv
// Shared pipeline-control definitions: debug FSM encoding and register-address width.
// Also imported by the forwarding unit and the pipeline registers.
package unit_hazard_pkg;
  localparam int NB_REG = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_STEP   = 2'b10
  } state_e;
endpackage

// File: rtl/unit_hazard_match.sv
// Combinational hit test of one producer destination against the ID-stage sources.
// Register 0 is hardwired to zero and never creates a dependency.
module unit_hazard_match #(
  parameter int NB_REG = 5
) (
  input  logic [NB_REG-1:0] dest,
  input  logic [NB_REG-1:0] rs,
  input  logic [NB_REG-1:0] rt,
  input  logic              uses_rt,
  output logic              hit
);
  assign hit = (dest != '0) && ((dest == rs) || (uses_rt && (dest == rt)));
endmodule

// File: rtl/unit_hazard.sv
// Stall controller: load-use / ID-branch hazards, data-memory freeze,
// debug halt/step FSM and a saturating stall-cycle counter.
module unit_hazard #(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [NB_REG-1:0] IF_ID_rs_i,
  input  logic [NB_REG-1:0] IF_ID_rt_i,
  input  logic              ID_uses_rt_i,
  input  logic              ID_branch_i,
  input  logic              ID_EX_mem_read_i,
  input  logic              ID_EX_reg_write_i,
  input  logic [NB_REG-1:0] ID_EX_write_reg_i,
  input  logic              EX_MEM_mem_read_i,
  input  logic [NB_REG-1:0] EX_MEM_write_reg_i,
  input  logic              dmem_busy_i,
  input  logic              halt_i,
  input  logic              run_i,
  input  logic              step_i,
  output logic              pc_write_o,
  output logic              IF_ID_write_o,
  output logic              ID_EX_flush_o,
  output logic              pipe_enable_o,
  output logic              halted_o,
  output logic [NB_CNT-1:0] stall_count_o
);
  import unit_hazard_pkg::*;

  localparam int N_MATCH = 3;

  // Slot 0: load-use on EX, slot 1: branch on EX, slot 2: branch on MEM load.
  logic [N_MATCH-1:0][NB_REG-1:0] dest;
  logic [N_MATCH-1:0]             hit;
  logic                           load_use, branch_haz, hazard;
  state_e                         state, state_nxt;

  assign dest = {EX_MEM_write_reg_i, ID_EX_write_reg_i, ID_EX_write_reg_i};

  for (genvar g = 0; g < N_MATCH; g++) begin : g_match
    unit_hazard_match #(.NB_REG(NB_REG)) u_match (
      .dest    (dest[g]),
      .rs      (IF_ID_rs_i),
      .rt      (IF_ID_rt_i),
      .uses_rt (ID_uses_rt_i),
      .hit     (hit[g])
    );
  end

  assign load_use   = ID_EX_mem_read_i & hit[0];
  assign branch_haz = ID_branch_i & ((ID_EX_reg_write_i & hit[1]) | (EX_MEM_mem_read_i & hit[2]));
  assign hazard     = load_use | branch_haz;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= ST_RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pc_write_o    = 1'b1;
    IF_ID_write_o = 1'b1;
    ID_EX_flush_o = 1'b0;
    pipe_enable_o = 1'b1;
    halted_o      = 1'b0;
    if (state == ST_HALTED) begin
      pc_write_o    = 1'b0;
      IF_ID_write_o = 1'b0;
      pipe_enable_o = 1'b0;
      halted_o      = 1'b1;
      if (run_i)       state_nxt = ST_RUN;
      else if (step_i) state_nxt = ST_STEP;
    end else begin
      // Memory wait freezes everything in place; a bubble here would lose the instruction in EX.
      if (dmem_busy_i) begin
        pc_write_o    = 1'b0;
        IF_ID_write_o = 1'b0;
        pipe_enable_o = 1'b0;
      end else if (hazard) begin
        pc_write_o    = 1'b0;
        IF_ID_write_o = 1'b0;
        ID_EX_flush_o = 1'b1;
      end
      case (state)
        ST_RUN:  if (halt_i) state_nxt = ST_HALTED;
        ST_STEP: if (!dmem_busy_i) state_nxt = ST_HALTED;
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      stall_count_o <= '0;
    else if ((state != ST_HALTED) && !pc_write_o && !(&stall_count_o))
      stall_count_o <= stall_count_o + NB_CNT'(1);
  end
endmodule
